// File: rtl/vga_anim_pkg.sv
// Shared definitions for the VGA animation sequencer: register map,
// CTRL field layout, FSM states and shadow-register reset values.
package vga_anim_pkg;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_DIV  = 2'd1;
    localparam logic [1:0] ADDR_LOAD = 2'd2;
    localparam logic [1:0] ADDR_CMD  = 2'd3;

    localparam int CTRL_EN_BIT  = 7;
    localparam int CTRL_PAT_LSB = 5;
    localparam int CTRL_DIR_BIT = 4;
    localparam int CTRL_STEP_W  = 4;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_STOP = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    typedef struct packed {
        logic                   enable;
        logic [1:0]             pattern_sel;
        logic                   dir;
        logic [CTRL_STEP_W-1:0] step;
    } ctrl_t;

    typedef struct packed {
        logic step_req;
        logic load_req;
    } cmd_t;

    localparam ctrl_t      CTRL_RESET = '{enable: 1'b1, pattern_sel: 2'd0, dir: 1'b0, step: 4'd1};
    localparam logic [7:0] DIV_RESET  = 8'd0;
    localparam logic [7:0] LOAD_RESET = 8'd0;
    localparam cmd_t       CMD_RESET  = '{step_req: 1'b0, load_req: 1'b0};

    function automatic ctrl_t decode_ctrl(input logic [7:0] data);
        decode_ctrl.enable      = data[CTRL_EN_BIT];
        decode_ctrl.pattern_sel = data[CTRL_PAT_LSB +: 2];
        decode_ctrl.dir         = data[CTRL_DIR_BIT];
        decode_ctrl.step        = data[CTRL_STEP_W-1:0];
    endfunction

endpackage

// File: rtl/vga_anim_cfg_if.sv
// Valid/ready configuration write port of the animation sequencer.
interface vga_anim_cfg_if;

    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);

endinterface

// File: rtl/vga_anim_sequencer_regs.sv
// Shadow register file: accepts config writes between frame ticks and
// clears the one-shot command bits when the frame tick consumes them.
module vga_anim_sequencer_regs
    import vga_anim_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    vga_anim_cfg_if.slave        cfg,
    output ctrl_t                shadow_ctrl,
    output logic [7:0]           shadow_div,
    output logic [7:0]           shadow_load,
    output cmd_t                 shadow_cmd
);

    ctrl_t      ctrl_q, ctrl_d;
    logic [7:0] div_q, div_d;
    logic [7:0] load_q, load_d;
    cmd_t       cmd_q, cmd_d;

    // Refusing writes on the tick cycle keeps a write and a commit from ever coinciding.
    assign cfg.cfg_ready = ~frame_tick;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        ctrl_d = ctrl_q;
        div_d  = div_q;
        load_d = load_q;
        cmd_d  = cmd_q;
        if (frame_tick) begin
            cmd_d = CMD_RESET;
        end else if (cfg.cfg_valid) begin
            unique case (cfg.cfg_addr)
                ADDR_CTRL: ctrl_d = decode_ctrl(cfg.cfg_data);
                ADDR_DIV:  div_d  = cfg.cfg_data;
                ADDR_LOAD: load_d = cfg.cfg_data;
                ADDR_CMD: begin
                    cmd_d.load_req = cmd_q.load_req | cfg.cfg_data[0];
                    cmd_d.step_req = cmd_q.step_req | cfg.cfg_data[1];
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_RESET;
            div_q  <= DIV_RESET;
            load_q <= LOAD_RESET;
            cmd_q  <= CMD_RESET;
        end else begin
            ctrl_q <= ctrl_d;
            div_q  <= div_d;
            load_q <= load_d;
            cmd_q  <= cmd_d;
        end
    end

    assign shadow_ctrl = ctrl_q;
    assign shadow_div  = div_q;
    assign shadow_load = load_q;
    assign shadow_cmd  = cmd_q;

endmodule

// File: rtl/vga_anim_sequencer.sv
// Frame-synchronous animation phase source: commits shadow config at each
// frame tick and runs the RUN/STOP/STEP sequencer, divider and phase adder.
module vga_anim_sequencer
    import vga_anim_pkg::*;
#(
    parameter int PHASE_W = 10,
    parameter int STEP_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    vga_anim_cfg_if.slave      cfg,
    output logic [PHASE_W-1:0] phase,
    output logic [1:0]         pattern_sel,
    output logic               commit,
    output logic               running
);

    ctrl_t      shadow_ctrl;
    logic [7:0] shadow_div;
    logic [7:0] shadow_load;
    cmd_t       shadow_cmd;

    vga_anim_sequencer_regs u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .cfg         (cfg),
        .shadow_ctrl (shadow_ctrl),
        .shadow_div  (shadow_div),
        .shadow_load (shadow_load),
        .shadow_cmd  (shadow_cmd)
    );

    state_e             state_q, state_d;
    ctrl_t              act_ctrl_q, act_ctrl_d;
    logic [7:0]         act_div_q, act_div_d;
    logic [7:0]         div_cnt_q, div_cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               commit_q, commit_d;

    logic [STEP_W-1:0]  step_a;
    logic [PHASE_W-1:0] phase_adv;

    assign step_a    = STEP_W'(act_ctrl_q.step);
    assign phase_adv = act_ctrl_q.dir ? phase_q - PHASE_W'(step_a)
                                      : phase_q + PHASE_W'(step_a);

    always_comb begin
        state_d    = state_q;
        act_ctrl_d = act_ctrl_q;
        act_div_d  = act_div_q;
        div_cnt_d  = div_cnt_q;
        phase_d    = phase_q;
        commit_d   = 1'b0;
        if (frame_tick) begin
            commit_d   = 1'b1;
            act_ctrl_d = shadow_ctrl;
            act_div_d  = shadow_div;
            // This frame's advance uses the pre-commit active settings.
            if (shadow_cmd.load_req) begin
                phase_d   = PHASE_W'(shadow_load);
                div_cnt_d = '0;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        // >= lets a shrunken DIV fire at once instead of wrapping the counter.
                        if (div_cnt_q >= act_div_q) begin
                            phase_d   = phase_adv;
                            div_cnt_d = '0;
                        end else begin
                            div_cnt_d = div_cnt_q + 8'd1;
                        end
                    end
                    ST_STEP: begin
                        phase_d   = phase_adv;
                        div_cnt_d = '0;
                    end
                    default: ;
                endcase
            end
            unique case (state_q)
                ST_RUN:  state_d = shadow_ctrl.enable ? ST_RUN : ST_STOP;
                default: state_d = shadow_ctrl.enable  ? ST_RUN  :
                                   shadow_cmd.step_req ? ST_STEP : ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            act_ctrl_q <= CTRL_RESET;
            act_div_q  <= DIV_RESET;
            div_cnt_q  <= '0;
            phase_q    <= '0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_ctrl_q <= act_ctrl_d;
            act_div_q  <= act_div_d;
            div_cnt_q  <= div_cnt_d;
            phase_q    <= phase_d;
            commit_q   <= commit_d;
        end
    end

    assign phase       = phase_q;
    assign pattern_sel = act_ctrl_q.pattern_sel;
    assign commit      = commit_q;
    assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_vga_anim_sequencer.sv
// Directed self-checking bench for vga_anim_sequencer.
module tb_vga_anim_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] phase;
    logic [1:0] pattern_sel;
    logic       commit;
    logic       running;

    int tests = 0;
    int fails = 0;
    int commit_cnt = 0;

    vga_anim_cfg_if cfg_if ();

    vga_anim_sequencer #(.PHASE_W(10), .STEP_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .cfg         (cfg_if.slave),
        .phase       (phase),
        .pattern_sel (pattern_sel),
        .commit      (commit),
        .running     (running)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && commit) commit_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_data  = d;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_data  = 8'd0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_pat", 32'(pattern_sel), 32'd0);
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_running", 32'(running), 32'd1);
        check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        rst_n = 1'b1;
        commit_cnt = 0;

        // Default: +1 per frame
        tick(); check("def_phase1", 32'(phase), 32'd1);
        check("def_commit_pulse", 32'(commit), 32'd1);
        tick(); check("def_phase2", 32'(phase), 32'd2);
        tick(); check("def_phase3", 32'(phase), 32'd3);
        @(negedge clk);
        check("def_commit_low", 32'(commit), 32'd0);
        check("def_commit_cnt", 32'(commit_cnt), 32'd3);
        check("def_pat", 32'(pattern_sel), 32'd0);
        check("def_running", 32'(running), 32'd1);

        // Back-to-back ticks are independent frames
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        check("b2b_phase", 32'(phase), 32'd5);
        @(negedge clk);
        check("b2b_commit_cnt", 32'(commit_cnt), 32'd5);

        // DIV=2: commit tick still uses DIV=0, then every third tick
        cfg_write(2'd1, 8'd2);
        tick(); check("div_commit", 32'(phase), 32'd6);
        tick(); check("div_t1", 32'(phase), 32'd6);
        tick(); check("div_t2", 32'(phase), 32'd6);
        tick(); check("div_t3", 32'(phase), 32'd7);
        tick(); check("div_t4", 32'(phase), 32'd7);
        tick(); check("div_t5", 32'(phase), 32'd7);
        tick(); check("div_t6", 32'(phase), 32'd8);

        // Down count by 4 with wrap
        do_reset();
        check("wrap_rst", 32'(phase), 32'd0);
        tick(); check("wrap_p1", 32'(phase), 32'd1);
        cfg_write(2'd0, 8'h94);
        tick(); check("wrap_commit", 32'(phase), 32'd2);
        tick(); check("wrap_down", 32'(phase), 32'd1022);
        tick(); check("wrap_down2", 32'(phase), 32'd1018);

        // LOAD with priority over advance, CMD self-clears
        do_reset();
        cfg_write(2'd2, 8'h55);
        cfg_write(2'd3, 8'h01);
        check("load_cmd_set", 32'(dut.u_regs.cmd_q), 32'd1);
        tick(); check("load_phase", 32'(phase), 32'h055);
        check("load_cmd_clr", 32'(dut.u_regs.cmd_q), 32'd0);
        tick(); check("load_next", 32'(phase), 32'h056);

        // STOP, single step, then re-enable with step=0
        do_reset();
        cfg_write(2'd0, 8'h01);
        tick(); check("stop_commit", 32'(phase), 32'd1);
        check("stop_running", 32'(running), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("stop_frozen", 32'(phase), 32'd1);
        cfg_write(2'd3, 8'h02);
        tick(); check("step_commit", 32'(phase), 32'd1);
        check("step_running", 32'(running), 32'd0);
        tick(); check("step_adv", 32'(phase), 32'd2);
        tick(); check("step_frozen", 32'(phase), 32'd2);
        cfg_write(2'd0, 8'h80);
        tick(); check("en_commit", 32'(phase), 32'd2);
        check("en_running", 32'(running), 32'd1);
        tick(); check("step0_noop", 32'(phase), 32'd2);

        // pattern_sel commit and write held across a frame tick
        do_reset();
        cfg_write(2'd0, 8'hC1);
        check("pat_before", 32'(pattern_sel), 32'd0);
        tick(); check("pat_after", 32'(pattern_sel), 32'd2);
        check("pat_phase", 32'(phase), 32'd1);
        @(negedge clk);
        frame_tick       = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = 2'd1;
        cfg_if.cfg_data  = 8'd5;
        #1 check("held_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
        @(negedge clk);
        frame_tick = 1'b0;
        #1 check("held_ready_high", 32'(cfg_if.cfg_ready), 32'd1);
        check("held_not_taken", 32'(dut.u_regs.div_q), 32'd0);
        check("held_phase", 32'(phase), 32'd2);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        check("held_taken", 32'(dut.u_regs.div_q), 32'd5);

        // Asynchronous reset mid-frame
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_phase", 32'(phase), 32'd0);
        check("arst_pat", 32'(pattern_sel), 32'd0);
        check("arst_commit", 32'(commit), 32'd0);
        check("arst_running", 32'(running), 32'd1);
        check("arst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check("arst_div", 32'(dut.u_regs.div_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check("arst_resume", 32'(phase), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
